// File: rtl/carregador_programa.sv
// Boot-time program loader: length-prefixed byte stream -> big-endian 32-bit words
// written to program memory from address 0. Optional trailing XOR checksum: CARREGADOR_CHECKSUM_EN.
module carregador_programa #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [31:0]       mp_data,
  output logic [31:0]       mp_addr,
  output logic              mp_wr,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR} state_t;

  // Where the load goes once the last word (or an empty image) is through
`ifdef CARREGADOR_CHECKSUM_EN
  localparam state_t FINISH = CHECK;
`else
  localparam state_t FINISH = DONE;
`endif

  state_t             state, state_nx;
  logic [7:0]         len_hi;
  logic [15:0]        len;
  logic [31:0]        word;
  logic [1:0]         byte_cnt;
  logic               accept;
  logic               last_word;
  logic [15:0]        len_cat;
  logic [ADDR_W:0]    wl_inc;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [7:0]         chk;
`endif

  assign accept    = byte_valid & byte_ready;
  assign len_cat   = {len_hi, byte_in};
  assign wl_inc    = words_loaded + (ADDR_W+1)'(1);
  assign last_word = 32'(wl_inc) == 32'(len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    case (state)
      IDLE, DONE, ERR: if (start) state_nx = LEN_HI;
      LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (32'(len_cat) > (32'd1 << ADDR_W)) state_nx = ERR;
          else if (len_cat == 16'd0)            state_nx = FINISH;
          else                                  state_nx = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_cnt == 2'd3) state_nx = WRITE;
      end
      WRITE: state_nx = last_word ? FINISH : DATA;
`ifdef CARREGADOR_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = (byte_in == chk) ? DONE : ERR;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs are registered off the next state so they line up with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi       <= '0;
      len          <= '0;
      word         <= '0;
      byte_cnt     <= '0;
      mp_data      <= '0;
      mp_addr      <= '0;
      mp_wr        <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
      chk          <= '0;
`endif
    end else begin
      mp_wr    <= (state_nx == WRITE);
      done     <= (state_nx == DONE);
      error    <= (state_nx == ERR);
      cpu_hold <= (state_nx != DONE);
      case (state)
        IDLE, DONE, ERR: if (start) begin
          words_loaded <= '0;
          byte_cnt     <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
          chk          <= '0;
`endif
        end
        LEN_HI: if (accept) len_hi <= byte_in;
        LEN_LO: if (accept) len <= len_cat;
        DATA: if (accept) begin
          word     <= {word[23:0], byte_in};
          byte_cnt <= byte_cnt + 2'd1;
`ifdef CARREGADOR_CHECKSUM_EN
          chk      <= chk ^ byte_in;
`endif
          // Capture the completed word so it is stable through the WRITE cycle
          if (byte_cnt == 2'd3) begin
            mp_data <= {word[23:0], byte_in};
            mp_addr <= 32'(words_loaded[ADDR_W-1:0]);
          end
        end
        WRITE: words_loaded <= wl_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_programa.sv
// Bench for carregador_programa: table of whole-image loads plus hand sequences,
// with a write scoreboard fed at stimulus time and drained on mp_wr.
module tb_carregador_programa;

`ifdef CARREGADOR_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mp_wr, cpu_hold, done, error;
  logic [31:0] mp_data, mp_addr;
  logic [4:0]  words_loaded;

  carregador_programa #(.ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mp_data(mp_data), .mp_addr(mp_addr), .mp_wr(mp_wr),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, wr_cnt = 0, first_hs = 0, last_wr_cyc = 0;
  logic prev_wr = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] img [0:15];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write monitor / scoreboard drain
  always @(negedge clk) begin
    if (mp_wr) begin
      logic [63:0] e;
      wr_cnt++;
      last_wr_cyc = cyc;
      chk("wr_pulse_width", 64'(prev_wr), 64'(0));
      chk("ready_in_write", 64'(byte_ready), 64'(0));
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", mp_addr, mp_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mp_addr), 64'(e[63:32]));
        chk("wr_data", 64'(mp_data), 64'(e[31:0]));
      end
    end
    prev_wr = mp_wr;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit tog, output int hs);
    int t = 0;
    if (tog) begin byte_valid = 1'b0; @(negedge clk); end
    byte_in = b; byte_valid = 1'b1;
    while (!byte_ready && t < 20) begin @(negedge clk); t++; end
    hs = cyc;
    if (!byte_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL byte_timeout: got ready 0 expected 1 for byte %0h", b);
    end else @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic load(input logic [15:0] len, input int nw, input bit tog, input bit tail, input bit flip);
    logic [7:0] x; int hc;
    x = 8'h00;
    pulse_start();
    send_byte(len[15:8], tog, hc);
    send_byte(len[7:0], tog, hc);
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back({32'(i), img[i]});
      for (int b = 3; b >= 0; b--) begin
        send_byte(img[i][8*b +: 8], tog, hc);
        x ^= img[i][8*b +: 8];
        if (i == 0 && b == 3) first_hs = hc;
      end
    end
    if (CHK_EN && tail) send_byte(x ^ {7'd0, flip}, tog, hc);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] len; int nw; bit tog; bit tail; bit flip;
    bit e_done; bit e_err; int e_wl;
  } vec_t;
  vec_t vecs [0:5];

  task automatic check_status(input string tag, input bit e_done, input bit e_err, input int e_wl);
    chk({tag, "_done"},  64'(done),         64'(e_done));
    chk({tag, "_error"}, 64'(error),        64'(e_err));
    chk({tag, "_hold"},  64'(cpu_hold),     64'(!e_done));
    chk({tag, "_wl"},    64'(words_loaded), 64'(e_wl));
    chk({tag, "_ready"}, 64'(byte_ready),   64'(0));
  endtask

  initial begin
    int base, hc;
    img[0] = 32'h8C010005;
    img[1] = 32'h00000007;
    for (int i = 2; i < 16; i++) img[i] = 32'(i) * 32'h01030507;

    vecs[0] = '{16'd2,  2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    vecs[1] = '{16'd2,  2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    vecs[2] = '{16'd17, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{16'd1,  1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{16'd0,  0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[5] = '{16'd16, 16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(byte_ready), 64'(0));
    chk("rst_mp_wr", 64'(mp_wr), 64'(0));
    chk("rst_data",  64'(mp_data), 64'(0));
    chk("rst_addr",  64'(mp_addr), 64'(0));
    chk("rst_hold",  64'(cpu_hold), 64'(1));
    chk("rst_done",  64'(done), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_wl",    64'(words_loaded), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      base = wr_cnt;
      load(vecs[v].len, vecs[v].nw, vecs[v].tog, vecs[v].tail, vecs[v].flip);
      check_status($sformatf("vec%0d", v), vecs[v].e_done, vecs[v].e_err, vecs[v].e_wl);
      chk($sformatf("vec%0d_writes", v), 64'(wr_cnt - base), 64'(vecs[v].nw));
      if (v == 0) chk("span_first_byte_to_last_wr", 64'(last_wr_cyc - first_hs), 64'(9));
    end

    if (CHK_EN) begin
      // Empty image with bad checksum
      load(16'd0, 0, 1'b0, 1'b1, 1'b1);
      check_status("n0_badchk", 1'b0, 1'b1, 0);
      img[0] = 32'h12345678;
      load(16'd1, 1, 1'b0, 1'b1, 1'b0);
      check_status("chk08", 1'b1, 1'b0, 1);
      load(16'd1, 1, 1'b0, 1'b1, 1'b1);
      check_status("chk09", 1'b0, 1'b1, 1);
      img[0] = 32'h8C010005;
    end

    // Reset after 6 data bytes of an N=3 load
    base = wr_cnt;
    pulse_start();
    send_byte(8'h00, 1'b0, hc);
    send_byte(8'h03, 1'b0, hc);
    exp_q.push_back({32'd0, img[0]});
    for (int b = 3; b >= 0; b--) send_byte(img[0][8*b +: 8], 1'b0, hc);
    send_byte(img[1][31:24], 1'b0, hc);
    send_byte(img[1][23:16], 1'b0, hc);
    chk("midrst_word0_written", 64'(wr_cnt - base), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", 64'(byte_ready), 64'(0));
    chk("midrst_mp_wr", 64'(mp_wr), 64'(0));
    chk("midrst_data",  64'(mp_data), 64'(0));
    chk("midrst_addr",  64'(mp_addr), 64'(0));
    chk("midrst_hold",  64'(cpu_hold), 64'(1));
    chk("midrst_done",  64'(done), 64'(0));
    chk("midrst_error", 64'(error), 64'(0));
    chk("midrst_wl",    64'(words_loaded), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    load(16'd2, 2, 1'b0, 1'b1, 1'b0);
    check_status("after_rst", 1'b1, 1'b0, 2);

    // start in DONE reloads and reasserts hold
    pulse_start();
    chk("reload_hold",  64'(cpu_hold), 64'(1));
    chk("reload_done",  64'(done), 64'(0));
    chk("reload_ready", 64'(byte_ready), 64'(1));

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
